// File: rtl/yuv422_to_rgb.sv
// yuv422_to_rgb
//   Converts one beat of four YUV422 pixels into four RGB888 pixels through a
//   three-stage pipeline. Every stage has its own valid flag.
//     S1: the Y/U/V bytes are registered, with D = U-128 and E = V-128 held as
//         9-bit signed values.
//     S2: the rounded chroma products for each U/V pair are registered.
//     S3: the clamped RGB pixels are registered. S3 drives rgb_o and
//         rgb_valid_o.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   reset_i      asynchronous, active-high; clears every stage flag and data
//                register
//   yuv_i        64-bit beat, bytes MSB first: Y0,U0,Y1,V0,Y2,U2,Y3,V2
//   yuv_valid_i  yuv_i holds a beat
//   yuv_ready_o  the block takes a beat this cycle
//   rgb_o        96-bit beat, pixel0 at [95:72]; each pixel is {R,G,B}
//   rgb_valid_o  rgb_o holds a beat
//   rgb_ready_i  downstream takes rgb_o this cycle
//
// Handshake: a beat moves across an interface on a rising edge only when the
// valid and ready for that interface are both 1. A producer holds valid and
// data stable until the beat is taken. The ready of this block is combinational
// and depends only on the S3 valid flag and rgb_ready_i. It never depends on
// yuv_valid_i. The pipeline uses a global stall. All stages move together
// unless a beat in S3 is blocked, so empty stages are filled as the pipeline
// advances.
module yuv422_to_rgb #(
  parameter int PIXEL_PER_CLK = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] yuv_i,
  input  logic        yuv_valid_i,
  output logic        yuv_ready_o,
  output logic [95:0] rgb_o,
  output logic        rgb_valid_o,
  input  logic        rgb_ready_i
);

  localparam int NUM_PIX   = PIXEL_PER_CLK;
  localparam int NUM_PAIRS = PIXEL_PER_CLK / 2;

  logic                advance;

  logic                s1_valid_q, s1_valid_d;
  logic        [7:0]   s1_y_q [NUM_PIX];
  logic        [7:0]   s1_y_d [NUM_PIX];
  logic signed [8:0]   s1_d_q [NUM_PAIRS];
  logic signed [8:0]   s1_d_d [NUM_PAIRS];
  logic signed [8:0]   s1_e_q [NUM_PAIRS];
  logic signed [8:0]   s1_e_d [NUM_PAIRS];

  logic                s2_valid_q, s2_valid_d;
  logic        [7:0]   s2_y_q [NUM_PIX];
  logic        [7:0]   s2_y_d [NUM_PIX];
  logic signed [17:0]  s2_r_q [NUM_PAIRS];
  logic signed [17:0]  s2_r_d [NUM_PAIRS];
  logic signed [17:0]  s2_g_q [NUM_PAIRS];
  logic signed [17:0]  s2_g_d [NUM_PAIRS];
  logic signed [17:0]  s2_b_q [NUM_PAIRS];
  logic signed [17:0]  s2_b_d [NUM_PAIRS];

  logic                s3_valid_q, s3_valid_d;
  logic        [95:0]  s3_rgb_q, s3_rgb_d;

  // Sign-extends a chroma offset to the 18-bit arithmetic width.
  function automatic logic signed [17:0] sx9(input logic signed [8:0] v);
    return {{9{v[8]}}, v};
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 18'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  // The chroma terms already include the +128 rounding offset. The >>> on a
  // signed operand is a floor shift.
  function automatic logic [23:0] pix_rgb(input logic        [7:0]  y,
                                          input logic signed [17:0] rt,
                                          input logic signed [17:0] gt,
                                          input logic signed [17:0] bt);
    logic signed [17:0] yx;
    logic signed [17:0] r;
    logic signed [17:0] g;
    logic signed [17:0] b;
    yx = {10'd0, y};
    r  = yx + (rt >>> 8);
    g  = yx - (gt >>> 8);
    b  = yx + (bt >>> 8);
    return {clamp8(r), clamp8(g), clamp8(b)};
  endfunction

  // Only a blocked beat in S3 stalls the pipeline.
  assign advance     = !(s3_valid_q && !rgb_ready_i);
  assign yuv_ready_o = advance;
  assign rgb_o       = s3_rgb_q;
  assign rgb_valid_o = s3_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s3_valid_d = s3_valid_q;
    s1_y_d     = s1_y_q;
    s1_d_d     = s1_d_q;
    s1_e_d     = s1_e_q;
    s2_y_d     = s2_y_q;
    s2_r_d     = s2_r_q;
    s2_g_d     = s2_g_q;
    s2_b_d     = s2_b_q;
    s3_rgb_d   = s3_rgb_q;

    if (advance) begin
      s1_valid_d = yuv_valid_i;
      s2_valid_d = s1_valid_q;
      s3_valid_d = s2_valid_q;

      // Pair p holds bytes Y(2p), U(2p), Y(2p+1), V(2p), starting at the MSB.
      for (int p = 0; p < NUM_PAIRS; p++) begin
        s1_y_d[2*p]   = yuv_i[63-32*p -: 8];
        s1_y_d[2*p+1] = yuv_i[47-32*p -: 8];
        s1_d_d[p]     = $signed({1'b0, yuv_i[55-32*p -: 8]}) - 9'sd128;
        s1_e_d[p]     = $signed({1'b0, yuv_i[39-32*p -: 8]}) - 9'sd128;
      end

      s2_y_d = s1_y_q;
      for (int p = 0; p < NUM_PAIRS; p++) begin
        s2_r_d[p] = 18'sd359 * sx9(s1_e_q[p]) + 18'sd128;
        s2_g_d[p] = 18'sd88 * sx9(s1_d_q[p]) + 18'sd183 * sx9(s1_e_q[p]) + 18'sd128;
        s2_b_d[p] = 18'sd454 * sx9(s1_d_q[p]) + 18'sd128;
      end

      for (int k = 0; k < NUM_PIX; k++) begin
        s3_rgb_d[95-24*k -: 24] = pix_rgb(s2_y_q[k], s2_r_q[k/2], s2_g_q[k/2], s2_b_q[k/2]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_rgb_q   <= '0;
      for (int k = 0; k < NUM_PIX; k++) begin
        s1_y_q[k] <= '0;
        s2_y_q[k] <= '0;
      end
      for (int p = 0; p < NUM_PAIRS; p++) begin
        s1_d_q[p] <= '0;
        s1_e_q[p] <= '0;
        s2_r_q[p] <= '0;
        s2_g_q[p] <= '0;
        s2_b_q[p] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      s3_rgb_q   <= s3_rgb_d;
      s1_y_q     <= s1_y_d;
      s1_d_q     <= s1_d_d;
      s1_e_q     <= s1_e_d;
      s2_y_q     <= s2_y_d;
      s2_r_q     <= s2_r_d;
      s2_g_q     <= s2_g_d;
      s2_b_q     <= s2_b_d;
    end
  end

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// Testbench for yuv422_to_rgb. The reference model is written directly from
// the colour equations using integer arithmetic and floor division.
module tb_yuv422_to_rgb;

  logic        clk;
  logic        reset_i;
  logic [63:0] yuv_i;
  logic        yuv_valid_i;
  logic        yuv_ready_o;
  logic [95:0] rgb_o;
  logic        rgb_valid_o;
  logic        rgb_ready_i;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_count = 0;
  logic [95:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [95:0] prev_rgb = '0;

  yuv422_to_rgb #(.PIXEL_PER_CLK(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .yuv_i       (yuv_i),
    .yuv_valid_i (yuv_valid_i),
    .yuv_ready_o (yuv_ready_o),
    .rgb_o       (rgb_o),
    .rgb_valid_o (rgb_valid_o),
    .rgb_ready_i (rgb_ready_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int fdiv256(input int a);
    if (a >= 0) return a / 256;
    return -((-a + 255) / 256);
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [95:0] model(input logic [63:0] beat);
    logic [7:0]  bb [8];
    logic [95:0] res;
    int y, d, e, r, g, b, p;
    for (int i = 0; i < 8; i++) bb[i] = beat[63-8*i -: 8];
    res = '0;
    for (int k = 0; k < 4; k++) begin
      p = k / 2;
      y = int'(bb[2*k]);
      d = int'(bb[4*p+1]) - 128;
      e = int'(bb[4*p+3]) - 128;
      r = clamp(y + fdiv256(359 * e + 128));
      g = clamp(y - fdiv256(88 * d + 183 * e + 128));
      b = clamp(y + fdiv256(454 * d + 128));
      res[95-24*k -: 24] = {8'(r), 8'(g), 8'(b)};
    end
    return res;
  endfunction

  function automatic logic [63:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (yuv_ready_o !== !(rgb_valid_o && !rgb_ready_i)) begin
        errors++;
        $display("FAIL ready_comb: yuv_ready_o=%b rgb_valid_o=%b rgb_ready_i=%b", yuv_ready_o, rgb_valid_o, rgb_ready_i);
      end
      if (prev_stall) begin
        checks++;
        if (rgb_valid_o !== 1'b1 || rgb_o !== prev_rgb) begin
          errors++;
          $display("FAIL stall_hold: valid=%b rgb=%h required valid=1 rgb=%h", rgb_valid_o, rgb_o, prev_rgb);
        end
      end
      if (rgb_valid_o === 1'b1 && rgb_ready_i) begin
        checks++;
        out_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: rgb=%h with no outstanding beat", rgb_o);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          if (rgb_o !== e) begin
            errors++;
            $display("FAIL scoreboard: rgb=%h required %h", rgb_o, e);
          end
        end
      end
      if (yuv_valid_i && yuv_ready_o === 1'b1) exp_q.push_back(model(yuv_i));
      prev_stall = (rgb_valid_o === 1'b1) && !rgb_ready_i;
      prev_rgb   = rgb_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a beat and returns 1 time unit after the edge that accepts it.
  task automatic send_beat(input logic [63:0] beat);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    yuv_i = beat;
    yuv_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (yuv_ready_o === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        @(posedge clk);
        #1;
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: yuv_ready_o=%b required 1 within 200 cycles", yuv_ready_o);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    yuv_valid_i = 1'b0;
    rgb_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
    idle_cycles(4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [63:0] beat;
    reset_i = 1'b1;
    yuv_valid_i = 1'b0;
    yuv_i = '0;
    rgb_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rgb_valid_o !== 1'b0 || rgb_o !== 96'd0 || yuv_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b rgb=%h ready=%b required 0/0/1", rgb_valid_o, rgb_o, yuv_ready_o);
    end
    // Release reset and present a beat in the same cycle. The beat must be
    // accepted on the first edge and must appear 3 cycles later.
    beat = rand_beat();
    reset_i = 1'b0;
    yuv_i = beat;
    yuv_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (yuv_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: yuv_ready_o=%b required 1", yuv_ready_o);
    end
    @(posedge clk);
    #1;
    yuv_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rgb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: rgb_valid_o=%b required 0", rgb_valid_o);
    end
    @(negedge clk);
    checks++;
    if (rgb_valid_o !== 1'b1 || rgb_o !== model(beat)) begin
      errors++;
      $display("FAIL latency: valid=%b rgb=%h required 1 %h", rgb_valid_o, rgb_o, model(beat));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed(input string name, input logic [63:0] beat, input logic [95:0] expected);
    rgb_ready_i = 1'b1;
    send_beat(beat);
    yuv_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rgb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: rgb_valid_o=%b required 0", name, rgb_valid_o);
    end
    @(negedge clk);
    checks++;
    if (rgb_valid_o !== 1'b1 || rgb_o !== expected) begin
      errors++;
      $display("FAIL %s: valid=%b rgb=%h required 1 %h", name, rgb_valid_o, rgb_o, expected);
    end
    @(negedge clk);
    checks++;
    if (rgb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_one_cycle: rgb_valid_o=%b required 0", name, rgb_valid_o);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    rgb_ready_i = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++) send_beat(rand_beat());
    checks++;
    if (cyc - start != 8) begin
      errors++;
      $display("FAIL throughput: %0d cycles for 8 beats, required 8", cyc - start);
    end
    drain();
  endtask

  task automatic test_stream(input string name, input int nbeats, input int ready_pct, input int gap_pct);
    bit done;
    int start_out;
    done = 0;
    start_out = out_count;
    fork
      begin
        for (int i = 0; i < nbeats; i++) begin
          if ($urandom_range(99) < gap_pct) begin
            yuv_valid_i = 1'b0;
            yuv_i = rand_beat();
            idle_cycles($urandom_range(1, 2));
          end
          send_beat(rand_beat());
        end
        yuv_valid_i = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          rgb_ready_i = ($urandom_range(99) < ready_pct);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    checks++;
    if (out_count - start_out != nbeats) begin
      errors++;
      $display("FAIL %s_count: %0d outputs, required %0d", name, out_count - start_out, nbeats);
    end
  endtask

  task automatic test_reset_midstream();
    int start_out;
    rgb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(rand_beat());
    yuv_valid_i = 1'b0;
    checks++;
    if (rgb_valid_o !== 1'b1 || yuv_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midstream_full: valid=%b ready=%b required 1/0", rgb_valid_o, yuv_ready_o);
    end
    reset_i = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (rgb_valid_o !== 1'b0 || rgb_o !== 96'd0 || yuv_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: valid=%b rgb=%h ready=%b required 0/0/1", rgb_valid_o, rgb_o, yuv_ready_o);
    end
    rgb_ready_i = 1'b1;
    idle_cycles(2);
    reset_i = 1'b0;
    start_out = out_count;
    for (int i = 0; i < 3; i++) send_beat(rand_beat());
    drain();
    idle_cycles(5);
    checks++;
    if (out_count - start_out != 3) begin
      errors++;
      $display("FAIL midstream_after: %0d outputs, required 3", out_count - start_out);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset_i = 1'b1;
    yuv_i = '0;
    yuv_valid_i = 1'b0;
    rgb_ready_i = 1'b1;
    test_reset();
    drain();
    test_directed("grey",        64'h80808080_80808080, {4{24'h808080}});
    test_directed("clamp_low",   64'h008000FF_008000FF, {4{24'hB20000}});
    test_directed("clamp_high",  64'hFF00FF80_FF00FF80, {4{24'hFFFF1C}});
    test_directed("chroma_split", 64'h00FF0080_00800080,
                  {24'h0000E1, 24'h0000E1, 24'h000000, 24'h000000});
    test_back_to_back();
    test_stream("backpressure", 10, 50, 0);
    test_stream("random_stream", 150, 70, 20);
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yuv422_to_rgb.md
YUV422_TO_RGB -- requirements
Module: yuv422_to_rgb

Interface
REQ-001 SHALL have parameter PIXEL_PER_CLK, default 4, pixels per beat; fixed at 4 (even), other values unsupported.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port yuv_i  input  64  4-pixel YUV422 beat, byte order MSB first: Y0,U0,Y1,V0,Y2,U2,Y3,V2.
REQ-005 SHALL have port yuv_valid_i  input  1  yuv_i holds a valid beat.
REQ-006 SHALL have port yuv_ready_o  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port rgb_o  output  96  4 pixels RGB888; pixel0 at [95:72], pixel3 at [23:0]; each pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 SHALL have port rgb_valid_o  output  1  rgb_o holds a valid beat.
REQ-009 SHALL have port rgb_ready_i  input  1  downstream accepts rgb_o this cycle.

Function
REQ-010 SHALL accept a beat on a rising edge when yuv_valid_i and yuv_ready_o are both 1; a beat SHALL leave on a rising edge when rgb_valid_o and rgb_ready_i are both 1.
REQ-011 SHALL be a 3-stage pipeline with a valid flag per stage: S1 registers Y/U/V fields and signed D=U-128, E=V-128 (9-bit); S2 registers products; S3 registers clamped RGB, which drives rgb_o/rgb_valid_o.
REQ-012 SHALL have latency of exactly 3 cycles from acceptance to rgb_valid_o=1 when rgb_ready_i stays 1; throughput 1 beat/cycle.
REQ-013 SHALL drive yuv_ready_o = NOT(S3 valid AND NOT rgb_ready_i), combinationally.
REQ-014 SHALL advance all stages when yuv_ready_o=1 and hold all stage registers unchanged when yuv_ready_o=0 (global stall).
REQ-015 SHALL compute pixels 0,1 from U0/V0 and pixels 2,3 from U2/V2.
REQ-016 SHALL compute R = Y + ((359*E + 128) >>> 8).
REQ-017 SHALL compute G = Y - ((88*D + 183*E + 128) >>> 8).
REQ-018 SHALL compute B = Y + ((454*D + 128) >>> 8).
REQ-019 SHALL evaluate REQ-016..018 in signed arithmetic of at least 18 bits; >>> SHALL be an arithmetic (floor) shift.
REQ-020 SHALL clamp each channel result to 0..255: negative -> 0, above 255 -> 255.
REQ-021 SHALL leave rgb_o data content unspecified when rgb_valid_o=0; checkers SHALL only compare rgb_o while rgb_valid_o=1.
REQ-022 SHALL hold rgb_o and rgb_valid_o stable while rgb_valid_o=1 and rgb_ready_i=0.
REQ-023 SHALL neither drop nor duplicate beats: output order SHALL equal acceptance order, under arbitrary valid/ready patterns.
REQ-024 SHALL treat empty bubbles (stage valid=0) as slots that can be filled; beats SHALL NOT bypass stages.

Reset
REQ-025 SHALL, while reset_i=1, clear all stage valid flags and data registers to 0, giving rgb_valid_o=0, rgb_o=0 and yuv_ready_o=1.
REQ-026 SHALL discard every in-flight beat on reset assertion mid-operation; no discarded beat SHALL appear after release.
REQ-027 SHALL accept a beat on the first rising edge after reset_i falls.

Verification
REQ-028 SHALL cover neutral grey: yuv_i=0x80808080_80808080, ready=1 -> 3 cycles later rgb_o=0x808080 repeated 4 times, rgb_valid_o=1 for 1 cycle.
REQ-029 SHALL cover clamp low and red: Y=0, U=0x80, V=0xFF, all pixels -> each pixel 0xB20000.
REQ-030 SHALL cover clamp high and negative shift: Y=0xFF, U=0x00, V=0x80 -> each pixel 0xFFFF1C.
REQ-031 SHALL cover chroma split: yuv_i=0x00FF0080_00800080 -> pixels 0,1 = 0x0000E1; pixels 2,3 = 0x000000.
REQ-032 SHALL cover backpressure: 10 back-to-back beats with rgb_ready_i random 50% -> 10 outputs in order, no loss or duplicate, and rgb_o stable during stalls.
REQ-033 SHALL cover reset mid-stream: assert reset_i with 3 beats in flight -> rgb_valid_o=0 immediately; after release only newly sent beats emerge.
